// File: rtl/sha1_pkg.sv
// SHA-1 shared definitions: initial hash values, round constants, command encodings,
// phase FSM states and the per-round boolean/rotate helpers.
// Pure package; no timing or flow-control behaviour of its own.
package sha1_pkg;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hc3d2e1f0;

    localparam logic [31:0] K0 = 32'h5a827999;
    localparam logic [31:0] K1 = 32'h6ed9eba1;
    localparam logic [31:0] K2 = 32'h8f1bbcdc;
    localparam logic [31:0] K3 = 32'hca62c1d6;

    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam int         CHAIN_BIT = 2;

    localparam logic [6:0] LAST_LOAD  = 7'd15;
    localparam logic [6:0] LAST_ROUND = 7'd79;
    localparam logic [6:0] LAST_READ  = 7'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_FINAL,
        ST_READ
    } state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Round-dependent boolean function: choose / parity / majority / parity.
    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        logic [31:0] f;
        if (t < 7'd20)
            f = (b & c) | (~b & d);
        else if (t >= 7'd40 && t < 7'd60)
            f = (b & c) | (b & d) | (c & d);
        else
            f = b ^ c ^ d;
        return f;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        logic [31:0] k;
        if (t < 7'd20)
            k = K0;
        else if (t < 7'd40)
            k = K1;
        else if (t < 7'd60)
            k = K2;
        else
            k = K3;
        return k;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// Single SHA-1 round: combinational next A..E from current A..E, schedule word and index.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when to register the result.
// Ports: t (round index 0..79), a..e (working vars), w (schedule word), a_nxt..e_nxt.
module sha1_round
    import sha1_pkg::*;
(
    input  logic [6:0]  t,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] e,
    input  logic [31:0] w,
    output logic [31:0] a_nxt,
    output logic [31:0] b_nxt,
    output logic [31:0] c_nxt,
    output logic [31:0] d_nxt,
    output logic [31:0] e_nxt
);

    assign a_nxt = rotl(a, 5) + sha1_f(t, b, c, d) + e + sha1_k(t) + w;
    assign b_nxt = a;
    assign c_nxt = rotl(b, 30);
    assign d_nxt = c;
    assign e_nxt = d;

endmodule

// File: rtl/sha1_core.sv
// Iterative word-serial SHA-1 engine: 16-word block load, 80 rounds, digest read-out.
// Latency: write done 97 edges after strobe (81 with SHA1_FAST_LOAD_EN), read 5 edges.
// Backpressure: cmd_o[3] busy; strobes while busy are dropped, host must poll.
// Ports: clk_i, rst_i (sync, active-low), cmd_i {chain, op[1:0]}, cmd_w_i strobe,
//        text_i message word, text_o digest word, cmd_o {busy, last accepted cmd}.
// Option: SHA1_FAST_LOAD_EN overlaps rounds 0..15 with the word load.
module sha1_core
    import sha1_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [2:0]  cmd_i,
    input  logic        cmd_w_i,
    input  logic [31:0] text_i,
    output logic [31:0] text_o,
    output logic [3:0]  cmd_o
);

    state_t      state, state_nxt;
    logic [6:0]  cnt;
    logic [2:0]  cmd_r;
    logic [31:0] h [5];
    logic [31:0] a, b, c, d, e;
    logic [31:0] w_buf [16];

    logic        accept;
    logic [1:0]  op;
    logic [3:0]  t4, i3, i8, i14;
    logic [31:0] w_exp, w_cur;
    logic [31:0] a_nxt, b_nxt, c_nxt, d_nxt, e_nxt;

    assign op     = cmd_i[1:0];
    assign accept = cmd_w_i && (state == ST_IDLE);
    assign cmd_o  = {state != ST_IDLE, cmd_r};

    // W is a 16-entry ring: slot t mod 16 still holds W[t-16] when round t needs it,
    // and the 4-bit index arithmetic wraps for the t-3/t-8/t-14 taps.
    assign t4    = cnt[3:0];
    assign i3    = t4 + 4'd13;
    assign i8    = t4 + 4'd8;
    assign i14   = t4 + 4'd2;
    assign w_exp = rotl(w_buf[i3] ^ w_buf[i8] ^ w_buf[i14] ^ w_buf[t4], 1);

    always_comb begin
        w_cur = w_exp;
`ifdef SHA1_FAST_LOAD_EN
        if (state == ST_LOAD)
            w_cur = text_i;
        else if (cnt < 7'd16)
            w_cur = w_buf[t4];
`else
        if (cnt < 7'd16)
            w_cur = w_buf[t4];
`endif
    end

    sha1_round u_round (
        .t     (cnt),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e     (e),
        .w     (w_cur),
        .a_nxt (a_nxt),
        .b_nxt (b_nxt),
        .c_nxt (c_nxt),
        .d_nxt (d_nxt),
        .e_nxt (e_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && op == OP_WRITE)
                    state_nxt = ST_LOAD;
                else if (accept && op == OP_READ)
                    state_nxt = ST_READ;
            end
            ST_LOAD:  if (cnt == LAST_LOAD)  state_nxt = ST_ROUND;
            ST_ROUND: if (cnt == LAST_ROUND) state_nxt = ST_FINAL;
            ST_FINAL: state_nxt = ST_IDLE;
            ST_READ:  if (cnt == LAST_READ)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt    <= '0;
            cmd_r  <= '0;
            text_o <= '0;
            h[0]   <= IV0;
            h[1]   <= IV1;
            h[2]   <= IV2;
            h[3]   <= IV3;
            h[4]   <= IV4;
            a      <= '0;
            b      <= '0;
            c      <= '0;
            d      <= '0;
            e      <= '0;
            for (int i = 0; i < 16; i++)
                w_buf[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_r <= cmd_i;
                        cnt   <= '0;
                        if (op == OP_WRITE) begin
                            if (!cmd_i[CHAIN_BIT]) begin
                                h[0] <= IV0;
                                h[1] <= IV1;
                                h[2] <= IV2;
                                h[3] <= IV3;
                                h[4] <= IV4;
                                a    <= IV0;
                                b    <= IV1;
                                c    <= IV2;
                                d    <= IV3;
                                e    <= IV4;
                            end else begin
                                a <= h[0];
                                b <= h[1];
                                c <= h[2];
                                d <= h[3];
                                e <= h[4];
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    w_buf[t4] <= text_i;
`ifdef SHA1_FAST_LOAD_EN
                    // Round t runs alongside the load of word t; count continues into 16.
                    a   <= a_nxt;
                    b   <= b_nxt;
                    c   <= c_nxt;
                    d   <= d_nxt;
                    e   <= e_nxt;
                    cnt <= cnt + 7'd1;
`else
                    cnt <= (cnt == LAST_LOAD) ? 7'd0 : cnt + 7'd1;
`endif
                end
                ST_ROUND: begin
                    a <= a_nxt;
                    b <= b_nxt;
                    c <= c_nxt;
                    d <= d_nxt;
                    e <= e_nxt;
                    if (cnt >= 7'd16)
                        w_buf[t4] <= w_exp;
                    cnt <= (cnt == LAST_ROUND) ? 7'd0 : cnt + 7'd1;
                end
                ST_FINAL: begin
                    h[0] <= h[0] + a;
                    h[1] <= h[1] + b;
                    h[2] <= h[2] + c;
                    h[3] <= h[3] + d;
                    h[4] <= h[4] + e;
                end
                ST_READ: begin
                    text_o <= h[cnt[2:0]];
                    cnt    <= cnt + 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha1_core.sv
// Bench for sha1_core: directed known-answer vectors plus randomized command streams,
// checked every cycle against a cycle-level behavioural model with a plain SHA-1 reference.
`timescale 1ns/1ps
module tb_sha1_core;

    typedef logic [4:0][31:0]  dig_t;
    typedef logic [15:0][31:0] blk_t;

`ifdef SHA1_FAST_LOAD_EN
    localparam int LAT = 81;
`else
    localparam int LAT = 97;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [2:0]  cmd_i;
    logic        cmd_w_i;
    logic [31:0] text_i;
    logic [31:0] text_o;
    logic [3:0]  cmd_o;

    int errors = 0;
    int checks = 0;

    sha1_core dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cmd_i   (cmd_i),
        .cmd_w_i (cmd_w_i),
        .text_i  (text_i),
        .text_o  (text_o),
        .cmd_o   (cmd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference SHA-1 ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        logic [63:0] dbl;
        dbl = {x, x};
        return dbl[63 - n -: 32];
    endfunction

    function automatic dig_t iv_dig();
        dig_t v;
        v[0] = 32'h67452301; v[1] = 32'hefcdab89; v[2] = 32'h98badcfe;
        v[3] = 32'h10325476; v[4] = 32'hc3d2e1f0;
        return v;
    endfunction

    function automatic dig_t sha1_ref(input dig_t hin, input blk_t m);
        logic [31:0] w [80];
        logic [31:0] va, vb, vc, vd, ve, f, k, tmp;
        dig_t r;
        for (int t = 0; t < 80; t++) begin
            if (t < 16) w[t] = m[t];
            else        w[t] = rl(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        end
        va = hin[0]; vb = hin[1]; vc = hin[2]; vd = hin[3]; ve = hin[4];
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (vb & vc) | (~vb & vd);            k = 32'h5a827999; end
            else if (t < 40) begin f = vb ^ vc ^ vd;                       k = 32'h6ed9eba1; end
            else if (t < 60) begin f = (vb & vc) | (vb & vd) | (vc & vd);  k = 32'h8f1bbcdc; end
            else             begin f = vb ^ vc ^ vd;                       k = 32'hca62c1d6; end
            tmp = rl(va, 5) + f + ve + k + w[t];
            ve = vd; vd = vc; vc = rl(vb, 30); vb = va; va = tmp;
        end
        r[0] = hin[0] + va; r[1] = hin[1] + vb; r[2] = hin[2] + vc;
        r[3] = hin[3] + vd; r[4] = hin[4] + ve;
        return r;
    endfunction

    // ---------------- cycle-level behavioural model ----------------
    dig_t        m_h;
    blk_t        m_blk;
    logic [2:0]  m_cmd;
    logic [31:0] m_text;
    int          m_left = 0;
    int          m_lcnt = 0;
    int          m_rk = 0;
    bit          m_wr = 0;
    bit          m_valid = 0;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            m_h = iv_dig(); m_cmd = 3'b000; m_text = 32'h0;
            m_left = 0; m_lcnt = 0; m_rk = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_left != 0) begin
                if (m_wr) begin
                    if (m_lcnt < 16) begin
                        m_blk[m_lcnt] = text_i;
                        m_lcnt++;
                    end
                    m_left--;
                    if (m_left == 0) m_h = sha1_ref(m_h, m_blk);
                end else begin
                    m_text = m_h[m_rk];
                    m_rk++;
                    m_left--;
                end
            end else if (cmd_w_i) begin
                m_cmd = cmd_i;
                if (cmd_i[1:0] == 2'b10) begin
                    if (!cmd_i[2]) m_h = iv_dig();
                    m_wr = 1; m_left = LAT; m_lcnt = 0;
                end else if (cmd_i[1:0] == 2'b01) begin
                    m_wr = 0; m_left = 5; m_rk = 0;
                end
            end
        end
    end

    // Every-cycle comparison of the visible outputs against the model.
    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("cmd_o", {28'd0, cmd_o}, {28'd0, (m_left != 0), m_cmd});
            chk("text_o", text_o, m_text);
        end
    end

    // ---------------- drivers ----------------
    task automatic write_block(input logic chain, input blk_t blk, input bit noisy,
                               input int rst_at, output int nb);
        bit done;
        @(negedge clk_i);
        cmd_i = {chain, 2'b10};
        cmd_w_i = 1'b1;
        @(negedge clk_i);
        cmd_w_i = noisy;
        nb = 0;
        done = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            text_i = (cyc < 16) ? blk[cyc[3:0]] : $urandom;
            if (noisy) begin
                cmd_i = 3'($urandom);
                if (cyc >= 15) cmd_w_i = 1'b0;
            end
            rst_i = (cyc == rst_at) ? 1'b0 : 1'b1;
            if (!cmd_o[3]) begin
                done = 1;
                break;
            end
            nb++;
            @(negedge clk_i);
        end
        cmd_w_i = 1'b0;
        rst_i = 1'b1;
        if (!done) chk("write_timeout", 32'd1, 32'd0);
    endtask

    task automatic read_digest(output dig_t dg);
        @(negedge clk_i);
        cmd_i = 3'b001;
        cmd_w_i = 1'b1;
        @(negedge clk_i);
        cmd_w_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            dg[k] = text_o;
        end
    endtask

    task automatic chk_dig(input string name, input dig_t act, input dig_t exp);
        for (int k = 0; k < 5; k++) chk(name, act[k], exp[k]);
    endtask

    // ---------------- stimulus ----------------
    blk_t abc_blk, b1, b2, rb;
    dig_t abc_dig, two_dig, got;
    int   nb;

    initial begin
        abc_blk = '0;
        abc_blk[0] = 32'h61626380;
        abc_blk[15] = 32'h00000018;
        abc_dig[0] = 32'ha9993e36; abc_dig[1] = 32'h4706816a; abc_dig[2] = 32'hba3e2571;
        abc_dig[3] = 32'h7850c26c; abc_dig[4] = 32'h9cd0d89d;
        b1[0]  = 32'h61626364; b1[1]  = 32'h62636465; b1[2]  = 32'h63646566;
        b1[3]  = 32'h64656667; b1[4]  = 32'h65666768; b1[5]  = 32'h66676869;
        b1[6]  = 32'h6768696a; b1[7]  = 32'h68696a6b; b1[8]  = 32'h696a6b6c;
        b1[9]  = 32'h6a6b6c6d; b1[10] = 32'h6b6c6d6e; b1[11] = 32'h6c6d6e6f;
        b1[12] = 32'h6d6e6f70; b1[13] = 32'h6e6f7071; b1[14] = 32'h80000000;
        b1[15] = 32'h00000000;
        b2 = '0;
        b2[15] = 32'h000001c0;
        two_dig[0] = 32'h84983e44; two_dig[1] = 32'h1c3bd26e; two_dig[2] = 32'hbaae4aa1;
        two_dig[3] = 32'hf95129e5; two_dig[4] = 32'he54670f1;

        rst_i = 1'b0; cmd_i = 3'b000; cmd_w_i = 1'b0; text_i = 32'h0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        chk("reset_cmd_o", {28'd0, cmd_o}, 32'd0);
        chk("reset_text_o", text_o, 32'd0);

        // Pin the reference model on the published vectors.
        chk_dig("ref_abc", sha1_ref(iv_dig(), abc_blk), abc_dig);
        chk_dig("ref_two", sha1_ref(sha1_ref(iv_dig(), b1), b2), two_dig);

        read_digest(got);
        chk_dig("reset_digest", got, iv_dig());

        write_block(1'b0, abc_blk, 1'b0, -1, nb);
        chk("busy_cycles", nb, LAT);
        read_digest(got);
        chk_dig("abc_digest", got, abc_dig);

        write_block(1'b0, b1, 1'b0, -1, nb);
        write_block(1'b1, b2, 1'b1, -1, nb);
        chk("busy_cycles_noisy", nb, LAT);
        chk("cmd_after_noisy", {29'd0, cmd_o[2:0]}, 32'd6);
        read_digest(got);
        chk_dig("two_block_digest", got, two_dig);
        chk("cmd_after_read", {28'd0, cmd_o}, 32'd1);

        write_block(1'b0, abc_blk, 1'b0, 40, nb);
        chk("midrun_reset_cmd_o", {28'd0, cmd_o}, 32'd0);
        chk("midrun_reset_text_o", text_o, 32'd0);
        read_digest(got);
        chk_dig("midrun_reset_iv", got, iv_dig());
        write_block(1'b0, abc_blk, 1'b0, -1, nb);
        read_digest(got);
        chk_dig("abc_after_reset", got, abc_dig);

        for (int it = 0; it < 30; it++) begin
            int r;
            r = $urandom_range(0, 9);
            for (int k = 0; k < 16; k++) rb[k] = $urandom;
            if (r <= 4) begin
                write_block(1'($urandom), rb, 1'($urandom), -1, nb);
            end else if (r <= 6) begin
                read_digest(got);
            end else if (r == 7) begin
                @(negedge clk_i);
                cmd_i = {1'($urandom), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11};
                cmd_w_i = 1'b1;
                @(negedge clk_i);
                cmd_w_i = 1'b0;
            end else if (r == 8) begin
                repeat ($urandom_range(1, 5)) @(negedge clk_i);
            end else begin
                write_block(1'($urandom), rb, 1'($urandom), $urandom_range(0, 100), nb);
            end
        end

        repeat (3) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
